cmd_sched: RTL

//  Schedules the single command port of the Knight's command processor between two requesters:
//   the Bluetooth/UART wrapper (BLE) and the tour sequencer (TOUR).

---
 rtl/cmd_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : cmd_sched
// Purpose  : Arbitrates the single command port of the command processor
//            between the BLE wrapper and the tour sequencer. It keeps one
//            command in flight and returns each completion to the requester
//            that issued the command. A BLE TOUR launch switches the port to
//            tour ownership until the tour finishes.
// Options  : CMD_SCHED_WDOG_EN - when defined, a watchdog aborts a command
//            that stays in flight too long and replies 8'hEE to BLE.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_sched #(
   parameter bit          FAST_SIM = 1'b1,
   parameter logic [25:0] TMO_FULL = 26'd50000000,
   parameter logic [25:0] TMO_SIM  = 26'd4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_ble_cmd,
   input  logic        i_ble_cmd_rdy,
   output logic        o_ble_clr_cmd_rdy,
   input  logic [15:0] i_tour_cmd,
   input  logic        i_tour_cmd_rdy,
   output logic        o_tour_clr_cmd_rdy,
   output logic [15:0] o_cmd,
   output logic        o_cmd_rdy,
   input  logic        i_clr_cmd_rdy,
   input  logic        i_send_resp,
   input  logic        i_tour_go,
   input  logic        i_tour_done,
   output logic        o_ble_send_resp,
   output logic [7:0]  o_resp,
   output logic        o_tour_resp,
   output logic        o_in_tour,
   output logic        o_busy,
   output logic        o_timeout
);

   localparam logic [7:0]  c_RESP_DONE = 8'hA5;
   localparam logic [7:0]  c_RESP_TMO  = 8'hEE;
   localparam logic [25:0] c_LIMIT     = FAST_SIM ? TMO_SIM : TMO_FULL;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_in_tour, w_in_tour_nxt;
   logic        r_done_pend, w_done_pend_nxt;
   logic        r_owner, w_owner_nxt;      // 0 = BLE, 1 = TOUR
   logic [15:0] r_cmd, w_cmd_nxt;
   logic        r_ble_send_resp, w_ble_send_resp_nxt;
   logic [7:0]  r_resp, w_resp_nxt;
   logic        r_tour_resp, w_tour_resp_nxt;
   logic        w_ble_clr;
   logic        w_tour_clr;
   logic        w_abort;
   logic        w_wdog_hit;

`ifdef CMD_SCHED_WDOG_EN
   logic [25:0] r_wdog_cnt;
   logic        r_timeout;

   // Watchdog counter: held at zero in IDLE so it starts from zero on ISSUE entry
   always_ff @(posedge clk) begin
      if (rst || r_state == ST_IDLE)
         r_wdog_cnt <= 26'd0;
      else
         r_wdog_cnt <= r_wdog_cnt + 26'd1;
   end

   assign w_wdog_hit = (r_state != ST_IDLE) && ((r_wdog_cnt + 26'd1) == c_LIMIT);

   // Registered one-cycle timeout pulse
   always_ff @(posedge clk) begin
      if (rst)
         r_timeout <= 1'b0;
      else
         r_timeout <= w_abort;
   end

   assign o_timeout = r_timeout;
`else
   logic w_unused_cfg;

   assign w_wdog_hit   = 1'b0;
   assign o_timeout    = 1'b0;
   assign w_unused_cfg = ^{c_LIMIT, w_abort};
`endif

   // Next-state, acceptance handshake and response decisions
   always_comb begin
      w_state_nxt         = r_state;
      w_in_tour_nxt       = r_in_tour;
      w_done_pend_nxt     = r_done_pend | (i_tour_done & r_in_tour);
      w_owner_nxt         = r_owner;
      w_cmd_nxt           = r_cmd;
      w_ble_send_resp_nxt = 1'b0;
      w_resp_nxt          = r_resp;
      w_tour_resp_nxt     = 1'b0;
      w_ble_clr           = 1'b0;
      w_tour_clr          = 1'b0;
      w_abort             = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (r_done_pend && r_in_tour) begin
               // Tour finished: deferred BLE reply goes out before new work
               w_in_tour_nxt       = 1'b0;
               w_done_pend_nxt     = 1'b0;
               w_ble_send_resp_nxt = 1'b1;
               w_resp_nxt          = c_RESP_DONE;
            end else if (r_in_tour && i_tour_cmd_rdy) begin
               w_tour_clr  = 1'b1;
               w_cmd_nxt   = i_tour_cmd;
               w_owner_nxt = 1'b1;
               w_state_nxt = ST_ISSUE;
            end else if (!r_in_tour && i_ble_cmd_rdy) begin
               w_ble_clr   = 1'b1;
               w_cmd_nxt   = i_ble_cmd;
               w_owner_nxt = 1'b0;
               w_state_nxt = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (w_wdog_hit)
               w_abort = 1'b1;
            else if (i_clr_cmd_rdy)
               w_state_nxt = ST_WAIT;
         end

         ST_WAIT: begin
            if (i_tour_go && !r_owner) begin
               // BLE reply is held back until the tour completes
               w_in_tour_nxt = 1'b1;
               w_state_nxt   = ST_IDLE;
            end else if (i_send_resp) begin
               if (r_owner) begin
                  w_tour_resp_nxt = 1'b1;
               end else begin
                  w_ble_send_resp_nxt = 1'b1;
                  w_resp_nxt          = c_RESP_DONE;
               end
               w_state_nxt = ST_IDLE;
            end else if (w_wdog_hit) begin
               w_abort = 1'b1;
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_abort) begin
         // Watchdog abort always reports to BLE and tears down any tour
         w_state_nxt         = ST_IDLE;
         w_ble_send_resp_nxt = 1'b1;
         w_resp_nxt          = c_RESP_TMO;
         w_in_tour_nxt       = 1'b0;
         w_done_pend_nxt     = 1'b0;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_in_tour       <= 1'b0;
         r_done_pend     <= 1'b0;
         r_owner         <= 1'b0;
         r_cmd           <= 16'h0000;
         r_ble_send_resp <= 1'b0;
         r_resp          <= 8'h00;
         r_tour_resp     <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_in_tour       <= w_in_tour_nxt;
         r_done_pend     <= w_done_pend_nxt;
         r_owner         <= w_owner_nxt;
         r_cmd           <= w_cmd_nxt;
         r_ble_send_resp <= w_ble_send_resp_nxt;
         r_resp          <= w_resp_nxt;
         r_tour_resp     <= w_tour_resp_nxt;
      end
   end

   // Acceptance pulses are suppressed while reset is asserted
   assign o_ble_clr_cmd_rdy  = w_ble_clr & ~rst;
   assign o_tour_clr_cmd_rdy = w_tour_clr & ~rst;
   assign o_cmd              = r_cmd;
   assign o_cmd_rdy          = (r_state == ST_ISSUE);
   assign o_ble_send_resp    = r_ble_send_resp;
   assign o_resp             = r_resp;
   assign o_tour_resp        = r_tour_resp;
   assign o_in_tour          = r_in_tour;
   assign o_busy             = (r_state != ST_IDLE);

endmodule
`default_nettype wire
